// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 16-bit, 4-bit-opcode core.
// It sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and drives every time-varying
// datapath enable. Illegal opcodes lock the FSM in TRAP until reset.
// Optional: define CTRL_PERF_CNT_EN to add the retired_cnt / stall_cnt performance counters.
module multicycle_controller #(
    parameter int unsigned OPC_W   = 4,
    parameter int unsigned NUM_OPC = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             alu_zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             retire,
    output logic             trap,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0]      retired_cnt,
    output logic [31:0]      stall_cnt,
`endif
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [OPC_W-1:0] OpLw    = OPC_W'(0);
    localparam logic [OPC_W-1:0] OpSw    = OPC_W'(1);
    localparam logic [OPC_W-1:0] OpBeqz  = OPC_W'(10);
    localparam logic [OPC_W-1:0] OpBneqz = OPC_W'(11);
    // One extra bit so NUM_OPC == 2**OPC_W (no illegal opcodes) still compares correctly.
    localparam logic [OPC_W:0]   NumOpc  = (OPC_W + 1)'(NUM_OPC);

    state_e state_q, state_d;

    logic is_mem, is_sw, is_branch, taken, illegal;

    assign is_sw     = (opcode == OpSw);
    assign is_mem    = (opcode == OpLw) || is_sw;
    assign is_branch = (opcode == OpBeqz) || (opcode == OpBneqz);
    assign taken     = ((opcode == OpBeqz) && alu_zero) || ((opcode == OpBneqz) && !alu_zero);
    assign illegal   = ({1'b0, opcode} >= NumOpc);

    // State register; reset returns to FETCH immediately and drops any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (imem_ack) state_d = StDecode;
            StDecode: state_d = illegal ? StTrap : StExec;
            StExec: begin
                if (is_mem) begin
                    state_d = StMem;
                end else if (is_branch) begin
                    state_d = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dmem_ack) state_d = is_sw ? StFetch : StWb;
            end
            StWb:     state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StFetch; // unreachable codes recover
        endcase
    end

    // Strobe decode; everything is forced low while reset is asserted.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 1'b0;
        alu_en   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        retire   = 1'b0;
        trap     = 1'b0;
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                StExec: begin
                    alu_en = 1'b1;
                    if (is_branch) begin
                        retire = 1'b1;
                        if (taken) begin
                            pc_we  = 1'b1;
                            pc_src = 1'b1;
                        end
                    end
                end
                StMem: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_sw;
                    retire   = dmem_ack && is_sw;
                end
                StWb: begin
                    reg_we = 1'b1;
                    retire = 1'b1;
                end
                StTrap:  trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_q, retired_d, stall_q, stall_d;

    // Counter next-state: count retires and ack-wait cycles, frozen while trapped.
    always_comb begin
        retired_d = retired_q;
        stall_d   = stall_q;
        if (state_q != StTrap) begin
            if (retire) retired_d = retired_q + 32'd1;
            if (((state_q == StFetch) && !imem_ack) || ((state_q == StMem) && !dmem_ack)) begin
                stall_d = stall_q + 32'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= 32'd0;
            stall_q   <= 32'd0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver pushes a per-instruction summary
// computed from the ISA timing rules; the monitor accumulates strobes until retire and compares.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       alu_zero, imem_ack, dmem_ack;
    logic       imem_req, ir_we, pc_we, pc_src, alu_en, dmem_req, dmem_we, reg_we, retire, trap;
    logic [2:0] state_o;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_cnt, stall_cnt;
    int exp_retired = 0;
    int exp_stall   = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    typedef struct {
        int opc;
        int cycles;
        int reg_we;
        int dmem_we;
        int dmem_req;
        int pc_we;
        int taken;
        int ir_we;
    } exp_t;

    exp_t exp_q[$];

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .alu_zero   (alu_zero),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .imem_req   (imem_req),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_en     (alu_en),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .reg_we     (reg_we),
        .retire     (retire),
        .trap       (trap),
`ifdef CTRL_PERF_CNT_EN
        .retired_cnt(retired_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // All outputs together, for checks that expect every strobe low.
    function automatic int strobes();
        return int'({imem_req, ir_we, pc_we, pc_src, alu_en, dmem_req, dmem_we, reg_we, retire});
    endfunction

    // Monitor: per-instruction accumulators, compared against the scoreboard on retire.
    int a_cyc, a_reg, a_dwe, a_dreq, a_pc, a_tk, a_ir;
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (reset || !mon_en) begin
            a_cyc = 0; a_reg = 0; a_dwe = 0; a_dreq = 0; a_pc = 0; a_tk = 0; a_ir = 0;
        end else begin
            a_cyc++;
            a_reg  += int'(reg_we);
            a_dwe  += int'(dmem_we);
            a_dreq += int'(dmem_req);
            a_pc   += int'(pc_we);
            a_tk   += int'(pc_we && pc_src);
            a_ir   += int'(ir_we);
            check("req_overlap", int'(imem_req && dmem_req), 0);
            check("we_overlap", int'(reg_we && dmem_we), 0);
            if (retire) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("cycles op%0d", e.opc), a_cyc, e.cycles);
                    check($sformatf("reg_we op%0d", e.opc), a_reg, e.reg_we);
                    check($sformatf("dmem_we op%0d", e.opc), a_dwe, e.dmem_we);
                    check($sformatf("dmem_req op%0d", e.opc), a_dreq, e.dmem_req);
                    check($sformatf("pc_we op%0d", e.opc), a_pc, e.pc_we);
                    check($sformatf("taken op%0d", e.opc), a_tk, e.taken);
                    check($sformatf("ir_we op%0d", e.opc), a_ir, e.ir_we);
                end
                a_cyc = 0; a_reg = 0; a_dwe = 0; a_dreq = 0; a_pc = 0; a_tk = 0; a_ir = 0;
            end
        end
    end

    // Entered and left at a falling edge. di/dd: cycles of delay before each ack.
    task automatic run_instr(input int opc, input bit z, input int di, input int dd);
        exp_t e;
        int   iw   = 0;
        int   dw   = 0;
        bit   done = 1'b0;
        bit   mem  = (opc == 0) || (opc == 1);
        bit   wb   = !((opc == 1) || (opc == 10) || (opc == 11));
        bit   tk   = ((opc == 10) && z) || ((opc == 11) && !z);
        e.opc      = opc;
        e.cycles   = (di + 1) + 1 + 1 + (mem ? dd + 1 : 0) + (wb ? 1 : 0);
        e.reg_we   = wb ? 1 : 0;
        e.dmem_we  = (opc == 1) ? dd + 1 : 0;
        e.dmem_req = mem ? dd + 1 : 0;
        e.pc_we    = tk ? 2 : 1;
        e.taken    = tk ? 1 : 0;
        e.ir_we    = 1;
        exp_q.push_back(e);
`ifdef CTRL_PERF_CNT_EN
        exp_retired++;
        exp_stall += di + (mem ? dd : 0);
`endif
        for (int n = 0; n < 60 && !done; n++) begin
            opcode   = 4'(opc);
            alu_zero = z;
            // Outside the requesting state the acks are noise that must be ignored.
            if (imem_req) begin
                imem_ack = (iw >= di);
                iw++;
            end else begin
                imem_ack = 1'($urandom_range(0, 1));
            end
            if (dmem_req) begin
                dmem_ack = (dw >= dd);
                dw++;
            end else begin
                dmem_ack = 1'($urandom_range(0, 1));
            end
            #1;
            if (retire) done = 1'b1;
            @(negedge clk);
        end
        if (!done) check($sformatf("retire_timeout op%0d", opc), 0, 1);
    endtask

    initial begin
        reset    = 1'b1;
        opcode   = 4'd0;
        alu_zero = 1'b0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        #2;
        check("reset_state", int'(state_o), 0);
        check("reset_strobes", strobes(), 0);
        check("reset_trap", int'(trap), 0);
        #6;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Directed: add, lw with slow dmem, both branch polarities, sw.
        run_instr(2, 1'b0, 0, 0);
        run_instr(0, 1'b0, 0, 3);
        run_instr(10, 1'b1, 0, 0);
        run_instr(10, 1'b0, 0, 0);
        run_instr(11, 1'b0, 0, 0);
        run_instr(11, 1'b1, 0, 0);
        run_instr(1, 1'b0, 0, 0);
        run_instr(1, 1'b0, 2, 2);
        for (int i = 0; i < 200; i++) begin
            run_instr(int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        check("scoreboard_drained", exp_q.size(), 0);
`ifdef CTRL_PERF_CNT_EN
        check("retired_cnt", int'(retired_cnt), exp_retired);
        check("stall_cnt", int'(stall_cnt), exp_stall);
`endif

        // Illegal opcode: FETCH, DECODE, then TRAP with no strobes until reset.
        mon_en = 1'b0;
        for (int k = 0; k < 24; k++) begin
            opcode   = 4'b1101;
            imem_ack = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            alu_zero = 1'($urandom_range(0, 1));
            #1;
            if (k == 1) check("decode_state", int'(state_o), 1);
            if (k >= 2) begin
                check("trap_state", int'(state_o), 5);
                check("trap_flag", int'(trap), 1);
                check("trap_strobes", strobes(), 0);
            end
            @(negedge clk);
        end
`ifdef CTRL_PERF_CNT_EN
        check("trap_retired_frozen", int'(retired_cnt), exp_retired);
        check("trap_stall_frozen", int'(stall_cnt), exp_stall);
`endif
        #1;
        reset = 1'b1;
        #1;
        check("trap_reset_state", int'(state_o), 0);
        check("trap_reset_flag", int'(trap), 0);
        @(posedge clk);
        #2;
        reset    = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        #1;
        check("post_trap_imem_req", int'(imem_req), 1);
        check("post_trap_flag", int'(trap), 0);

        // Reset while a data access is outstanding.
        begin
            bit in_mem = 1'b0;
            for (int n = 0; n < 20 && !in_mem; n++) begin
                opcode   = 4'd0;
                imem_ack = imem_req;
                dmem_ack = 1'b0;
                #1;
                if (dmem_req) in_mem = 1'b1;
                else @(negedge clk);
            end
            check("reached_mem", int'(in_mem), 1);
            check("mem_dmem_we", int'(dmem_we), 0);
        end
        reset = 1'b1;
        #1;
        check("async_dmem_req_drop", int'(dmem_req), 0);
        check("async_state", int'(state_o), 0);
        check("async_strobes", strobes(), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("post_reset_imem_req", int'(imem_req), 1);
        check("post_reset_state", int'(state_o), 0);
`ifdef CTRL_PERF_CNT_EN
        check("post_reset_retired", int'(retired_cnt), 0);
        check("post_reset_stall", int'(stall_cnt), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM that sequences fetch, decode, execute, memory and writeback for the 16-bit, 4-bit-opcode core.
- Sits between the instruction register, instruction/data memory handshakes, the ALU zero flag and the instruction decoder.
- The decoder supplies static datapath selects. This block supplies all time-varying enables: IR/PC/register-file/memory strobes, branch redirect, retire and trap.

Parameters:
- OPC_W, 4, opcode width.
- NUM_OPC, 12, count of legal opcodes (0..NUM_OPC-1). Higher opcodes are illegal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  OPC_W  opcode field of the latched IR. Stable from DECODE until the next IR write.
- alu_zero  in  1  ALU result==0. Sampled in EXEC only.
- imem_ack  in  1  instruction memory has data. Valid only while imem_req=1.
- dmem_ack  in  1  data memory access complete. Valid only while dmem_req=1.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  load IR.
- pc_we  out  1  load PC.
- pc_src  out  1  0 = PC+2, 1 = branch target.
- alu_en  out  1  ALU operands/result valid this cycle.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (sw).
- reg_we  out  1  register file write strobe.
- retire  out  1  one-cycle pulse on the final cycle of each instruction.
- trap  out  1  sticky illegal-opcode flag.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6-7 are unreachable and recover to FETCH.
- Reset:
  - state=FETCH immediately (asynchronous).
  - All outputs 0 and trap=0, regardless of mid-instruction state.
  - An in-flight memory request is dropped.
- All strobe outputs are Moore/Mealy combinational decodes of state, opcode and the acks; no extra registering.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_we=1, pc_we=1, pc_src=0, go to DECODE.
  - Otherwise hold with no timeout.
- DECODE:
  - opcode>=NUM_OPC: go to TRAP.
  - Otherwise go to EXEC.
- EXEC: alu_en=1.
  - Opcodes 0 (lw) and 1 (sw): go to MEM.
  - Opcode 10 (beqz): taken = alu_zero.
  - Opcode 11 (bneqz): taken = !alu_zero.
  - Branch taken: pc_we=1, pc_src=1. Taken or not taken: retire=1, go to FETCH.
  - All other opcodes: go to WB.
- MEM:
  - dmem_req=1; dmem_we=(opcode==1).
  - Hold until dmem_ack.
  - sw on ack: retire=1, go to FETCH.
  - lw on ack: go to WB.
- WB: reg_we=1, retire=1, go to FETCH.
- TRAP:
  - trap=1 and state held until reset.
  - No req, we or retire outputs assert.
- Latency, counted from FETCH entry with same-cycle acks:
  - ALU op: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch: 3 cycles.
- Each ack wait adds one cycle per cycle of delay.
- Acks arriving outside their requesting state are ignored.
- imem_req and dmem_req are never asserted in the same cycle.
- reg_we and dmem_we are never asserted in the same cycle.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- When defined:
  - Adds outputs retired_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - retired_cnt increments on each retire pulse.
  - stall_cnt increments on every cycle in FETCH without imem_ack and every cycle in MEM without dmem_ack.
  - Both wrap 0xFFFFFFFF->0 and freeze in TRAP.
- When undefined: these ports and registers are absent. FSM behaviour is identical.

Test Plan:
- add (opcode 2), acks tied high -> state sequence 0,1,2,4,0. reg_we=1 only in cycle 4. retire pulses once. pc_we only in FETCH.
- lw (opcode 0), dmem_ack delayed 3 cycles -> MEM held 4 cycles with dmem_req=1, dmem_we=0. Then WB with reg_we=1. Total 8 cycles.
- beqz (opcode 10) with alu_zero=1 -> EXEC asserts pc_we=1, pc_src=1, retire=1. With alu_zero=0 -> pc_we=0, retire=1. Both return to FETCH after 3 cycles.
- sw (opcode 1) -> MEM asserts dmem_we=1, reg_we stays 0, retire on ack, next state FETCH.
- opcode 4'b1101 -> DECODE goes to TRAP. trap=1 held 20+ cycles with no strobes. reset clears trap and returns state to FETCH.
- reset asserted in MEM with dmem_req=1 -> dmem_req drops the same cycle (async). After release, FETCH with imem_req=1. With CTRL_PERF_CNT_EN, both counters read 0.
